// File: rtl/video_mnist_param_scheduler.sv
// Frame-synchronous parameter sequencer for the MNIST colouring core.
// Staged configuration is applied only on a start-of-frame handshake, with an
// optional auto-sweep of the threshold and a free-running frame counter.
module video_mnist_param_scheduler #(
    parameter int unsigned TUSER_WIDTH       = 1,
    parameter int unsigned TCOUNT_WIDTH      = 4,
    parameter int unsigned FRAME_COUNT_WIDTH = 16,
    parameter int unsigned DIV_WIDTH         = 8,
    parameter logic [1:0]  INIT_PARAM_MODE   = 2'b10,
    parameter int unsigned INIT_PARAM_TH     = 5
) (
    input  logic                         aresetn,
    input  logic                         aclk,
    input  logic [1:0]                   cfg_mode,
    input  logic [TCOUNT_WIDTH-1:0]      cfg_th,
    input  logic                         cfg_auto_en,
    input  logic [TCOUNT_WIDTH-1:0]      cfg_th_min,
    input  logic [TCOUNT_WIDTH-1:0]      cfg_th_max,
    input  logic [DIV_WIDTH-1:0]         cfg_frame_div,
    input  logic                         cfg_update,
    input  logic [TUSER_WIDTH-1:0]       mon_tuser,
    input  logic                         mon_tvalid,
    input  logic                         mon_tready,
    output logic [1:0]                   param_mode,
    output logic [TCOUNT_WIDTH-1:0]      param_th,
    output logic                         update_ack,
    output logic                         pending,
    output logic                         sweeping,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam logic [TCOUNT_WIDTH-1:0] INIT_TH = TCOUNT_WIDTH'(INIT_PARAM_TH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    state_t                         state_q, state_d;

    logic                           sof_c;
    logic [1:0]                     stg_mode_q, stg_mode_d;
    logic [TCOUNT_WIDTH-1:0]        stg_th_q, stg_th_d;
    logic                           stg_auto_q, stg_auto_d;
    logic [DIV_WIDTH-1:0]           div_cnt_q, div_cnt_d;
    logic [1:0]                     param_mode_d;
    logic [TCOUNT_WIDTH-1:0]        param_th_d;
    logic [TCOUNT_WIDTH-1:0]        th_step_c;
    logic                           update_ack_d;
    logic [FRAME_COUNT_WIDTH-1:0]   frame_count_d;

    // Start of frame: accepted beat carrying the SOF marker
    assign sof_c = mon_tvalid & mon_tready & mon_tuser[0];

    // Next sweep threshold; out-of-range or top-of-range wraps to the lower bound
    assign th_step_c = ((param_th >= cfg_th_max) || (param_th < cfg_th_min))
                       ? cfg_th_min
                       : param_th + TCOUNT_WIDTH'(1);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: any request re-enters PEND, otherwise SOF retires PEND
    always_comb begin
        state_d = state_q;
        if (cfg_update) begin
            state_d = S_PEND;
        end else if ((state_q == S_PEND) && sof_c) begin
            state_d = stg_auto_q ? S_SWEEP : S_IDLE;
        end
    end

    // Output / datapath next values; old staging is applied even if a new request lands on the SOF
    always_comb begin
        stg_mode_d    = stg_mode_q;
        stg_th_d      = stg_th_q;
        stg_auto_d    = stg_auto_q;
        div_cnt_d     = div_cnt_q;
        param_mode_d  = param_mode;
        param_th_d    = param_th;
        update_ack_d  = 1'b0;
        frame_count_d = frame_count;

        if (sof_c) begin
            frame_count_d = frame_count + FRAME_COUNT_WIDTH'(1);
        end

        if (cfg_update) begin
            stg_mode_d = cfg_mode;
            stg_th_d   = cfg_th;
            stg_auto_d = cfg_auto_en;
        end

        case (state_q)
            S_PEND: begin
                if (sof_c) begin
                    param_mode_d = stg_mode_q;
                    param_th_d   = stg_th_q;
                    update_ack_d = 1'b1;
                    div_cnt_d    = '0;
                end
            end
            S_SWEEP: begin
                if (sof_c && !cfg_update) begin
                    if (div_cnt_q == cfg_frame_div) begin
                        param_th_d = th_step_c;
                        div_cnt_d  = '0;
                    end else begin
                        div_cnt_d  = div_cnt_q + DIV_WIDTH'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs, staging and sweep divider
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stg_mode_q  <= '0;
            stg_th_q    <= '0;
            stg_auto_q  <= 1'b0;
            div_cnt_q   <= '0;
            param_mode  <= INIT_PARAM_MODE;
            param_th    <= INIT_TH;
            update_ack  <= 1'b0;
            pending     <= 1'b0;
            sweeping    <= 1'b0;
            frame_count <= '0;
        end else begin
            stg_mode_q  <= stg_mode_d;
            stg_th_q    <= stg_th_d;
            stg_auto_q  <= stg_auto_d;
            div_cnt_q   <= div_cnt_d;
            param_mode  <= param_mode_d;
            param_th    <= param_th_d;
            update_ack  <= update_ack_d;
            pending     <= (state_d == S_PEND);
            sweeping    <= (state_d == S_SWEEP);
            frame_count <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_video_mnist_param_scheduler.sv
// Scoreboard bench for video_mnist_param_scheduler: expected applied settings
// are queued when a request is driven and checked when update_ack fires.
module tb_video_mnist_param_scheduler;

    localparam int unsigned TW = 4;
    localparam int unsigned FW = 16;
    localparam int unsigned DW = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [TW-1:0] cfg_th = '0;
    logic          cfg_auto_en = 1'b0;
    logic [TW-1:0] cfg_th_min = '0;
    logic [TW-1:0] cfg_th_max = '0;
    logic [DW-1:0] cfg_frame_div = '0;
    logic          cfg_update = 1'b0;
    logic [0:0]    mon_tuser = '0;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic [1:0]    param_mode;
    logic [TW-1:0] param_th;
    logic          update_ack;
    logic          pending;
    logic          sweeping;
    logic [FW-1:0] frame_count;

    typedef struct packed {
        logic [1:0]    mode;
        logic [TW-1:0] th;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    logic [FW-1:0] exp_fc = '0;

    video_mnist_param_scheduler dut (
        .aresetn       (aresetn),
        .aclk          (aclk),
        .cfg_mode      (cfg_mode),
        .cfg_th        (cfg_th),
        .cfg_auto_en   (cfg_auto_en),
        .cfg_th_min    (cfg_th_min),
        .cfg_th_max    (cfg_th_max),
        .cfg_frame_div (cfg_frame_div),
        .cfg_update    (cfg_update),
        .mon_tuser     (mon_tuser),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .param_mode    (param_mode),
        .param_th      (param_th),
        .update_ack    (update_ack),
        .pending       (pending),
        .sweeping      (sweeping),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest queued expectation
    always @(negedge aclk) begin
        if (aresetn && (update_ack === 1'b1)) begin
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_mode", 32'(param_mode), 32'(e.mode));
                chk("ack_th", 32'(param_th), 32'(e.th));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic sof();
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = 1'b1;
        step(1);
        exp_fc++;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tuser  = 1'b0;
    endtask

    task automatic upd(input logic [1:0] m, input logic [TW-1:0] t, input logic a);
        cfg_mode    = m;
        cfg_th      = t;
        cfg_auto_en = a;
        cfg_update  = 1'b1;
        step(1);
        cfg_update  = 1'b0;
    endtask

    task automatic push(input logic [1:0] m, input logic [TW-1:0] t);
        exp_t e;
        e.mode = m;
        e.th   = t;
        sb_q.push_back(e);
    endtask

    initial begin
        int pc;
        int seq[7] = '{2, 3, 3, 4, 4, 2, 2};

        // Reset values
        step(2);
        chk("rst_mode", 32'(param_mode), 32'd2);
        chk("rst_th", 32'(param_th), 32'd5);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_flags", {29'd0, update_ack, pending, sweeping}, 32'd0);
        aresetn = 1'b1;
        step(2);

        // Single request, SOF 20 cycles later
        upd(2'd1, 4'd9, 1'b0);
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            pc += int'(pending);
            step(1);
        end
        chk("pend_hold", 32'(pc), 32'd20);
        push(2'd1, 4'd9);
        sof();
        chk("apply_th", 32'(param_th), 32'd9);
        chk("apply_mode", 32'(param_mode), 32'd1);
        chk("apply_ack", 32'(update_ack), 32'd1);
        chk("apply_pend", 32'(pending), 32'd0);
        chk("apply_sweep", 32'(sweeping), 32'd0);
        step(1);
        chk("ack_width", 32'(update_ack), 32'd0);

        // Latest request wins
        upd(2'd2, 4'd3, 1'b0);
        step(2);
        upd(2'd3, 4'd7, 1'b0);
        push(2'd3, 4'd7);
        step(3);
        sof();
        chk("ovr_th", 32'(param_th), 32'd7);
        step(2);
        sof();
        chk("idle_hold_th", 32'(param_th), 32'd7);
        chk("idle_fc", 32'(frame_count), 32'(exp_fc));

        // Request coincident with SOF while pending
        upd(2'd0, 4'd4, 1'b0);
        step(3);
        cfg_mode = 2'd1; cfg_th = 4'd11; cfg_auto_en = 1'b0; cfg_update = 1'b1;
        push(2'd0, 4'd4);
        sof();
        cfg_update = 1'b0;
        chk("coin_th", 32'(param_th), 32'd4);
        chk("coin_mode", 32'(param_mode), 32'd0);
        chk("coin_pend", 32'(pending), 32'd1);
        step(2);
        push(2'd1, 4'd11);
        sof();
        chk("coin2_th", 32'(param_th), 32'd11);
        chk("coin2_pend", 32'(pending), 32'd0);

        // Auto sweep 2..4 every second frame
        cfg_th_min = 4'd2; cfg_th_max = 4'd4; cfg_frame_div = 8'd1;
        upd(2'd1, 4'd2, 1'b1);
        push(2'd1, 4'd2);
        sof();
        chk("sw_start_th", 32'(param_th), 32'd2);
        chk("sw_flag", 32'(sweeping), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step(1);
            sof();
            chk($sformatf("sw_th%0d", i), 32'(param_th), 32'(seq[i]));
            chk("sw_mode", 32'(param_mode), 32'd1);
        end
        upd(2'd2, 4'd5, 1'b0);
        chk("sw_exit_pend", 32'(pending), 32'd1);
        chk("sw_exit_sweep", 32'(sweeping), 32'd0);
        push(2'd2, 4'd5);
        sof();
        chk("sw_exit_th", 32'(param_th), 32'd5);

        // Inverted bounds pin at min, div 0 steps each frame
        cfg_th_min = 4'd8; cfg_th_max = 4'd3; cfg_frame_div = 8'd0;
        upd(2'd2, 4'd6, 1'b1);
        push(2'd2, 4'd6);
        sof();
        chk("pin_start", 32'(param_th), 32'd6);
        sof();
        chk("pin_1", 32'(param_th), 32'd8);
        sof();
        chk("pin_2", 32'(param_th), 32'd8);
        upd(2'd2, 4'd5, 1'b0);
        push(2'd2, 4'd5);
        sof();

        // Non-SOF beats do not count frames
        mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tuser = 1'b1;
        step(5);
        mon_tready = 1'b1; mon_tuser = 1'b0;
        step(3);
        mon_tvalid = 1'b0; mon_tready = 1'b0;
        chk("nosof_fc", 32'(frame_count), 32'(exp_fc));

        // Reset while pending discards staging
        upd(2'd3, 4'd12, 1'b0);
        chk("pre_rst_pend", 32'(pending), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("arst_mode", 32'(param_mode), 32'd2);
        chk("arst_th", 32'(param_th), 32'd5);
        chk("arst_fc", 32'(frame_count), 32'd0);
        chk("arst_flags", {29'd0, update_ack, pending, sweeping}, 32'd0);
        exp_fc = '0;
        step(1);
        aresetn = 1'b1;
        step(1);
        sof();
        chk("post_rst_th", 32'(param_th), 32'd5);
        chk("post_rst_pend", 32'(pending), 32'd0);

        // Frame counter wrap over 70000 frames
        aresetn = 1'b0;
        step(1);
        aresetn = 1'b1;
        exp_fc = '0;
        step(1);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step(1);
            exp_fc++;
        end
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0;
        chk("fc_wrap", 32'(frame_count), 32'd4464);
        chk("fc_model", 32'(frame_count), 32'(exp_fc));

        step(2);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/video_mnist_param_scheduler.md
Name: video_mnist_param_scheduler

Overview:
Frame-synchronous parameter sequencer for the MNIST colouring core. It takes raw configuration (mode, threshold, update strobe) and applies it only at frame boundaries, detected on the core's input AXI4-Stream handshake, so a frame never mixes settings. An optional auto-sweep mode steps the threshold across a range every N frames for demo and calibration. It also counts frames for status read-back.

Parameters:
TUSER_WIDTH, 1, width of monitored tuser; bit 0 is start-of-frame
TCOUNT_WIDTH, 4, threshold width (matches core param_th)
FRAME_COUNT_WIDTH, 16, frame counter width
DIV_WIDTH, 8, frames-per-step divider width
INIT_PARAM_MODE, 2'b10, reset value of param_mode
INIT_PARAM_TH, 5, reset value of param_th

Ports:
aresetn  in  1  asynchronous active-low reset
aclk  in  1  clock; all logic on rising edge
cfg_mode  in  2  requested mode
cfg_th  in  TCOUNT_WIDTH  requested threshold / sweep start
cfg_auto_en  in  1  request auto-sweep after apply
cfg_th_min  in  TCOUNT_WIDTH  sweep lower bound
cfg_th_max  in  TCOUNT_WIDTH  sweep upper bound
cfg_frame_div  in  DIV_WIDTH  sweep step every cfg_frame_div+1 frames
cfg_update  in  1  single-cycle request to stage cfg_mode/cfg_th/cfg_auto_en
mon_tuser  in  TUSER_WIDTH  core input tuser (monitor only)
mon_tvalid  in  1  core input tvalid
mon_tready  in  1  core input tready
param_mode  out  2  applied mode to core
param_th  out  TCOUNT_WIDTH  applied threshold to core
update_ack  out  1  one-cycle pulse: staged config applied
pending  out  1  staged config waiting for frame start
sweeping  out  1  auto-sweep active
frame_count  out  FRAME_COUNT_WIDTH  frames seen, wraps

Behaviour:
- Clock aclk; reset aresetn is asynchronous and active-low. All outputs registered.
- Reset values: param_mode=INIT_PARAM_MODE, param_th=INIT_PARAM_TH, update_ack=0, pending=0, sweeping=0, frame_count=0, div_cnt=0, state IDLE, staging cleared. Reset mid-frame discards any staged request.
- sof = mon_tvalid & mon_tready & mon_tuser[0], evaluated each cycle.
- frame_count increments by 1 on every sof and wraps from all-ones to 0.
- States: IDLE, PEND, SWEEP. pending=(state==PEND). sweeping=(state==SWEEP).
- cfg_update in any state: stage {cfg_mode, cfg_th, cfg_auto_en}; next state PEND. Latest request wins (overwrite).
- PEND with sof and no cfg_update: on that edge load param_mode/param_th from staging. update_ack=1 for exactly the next cycle. div_cnt=0. Next state SWEEP if staged auto_en, else IDLE.
- PEND with sof and cfg_update in the same cycle: apply the OLD staging with an ack. Capture the new request. Stay PEND; the new request applies at the next sof.
- SWEEP with sof:
  - If div_cnt==cfg_frame_div: step param_th and clear div_cnt; otherwise div_cnt+1.
  - Step rule: if param_th>=cfg_th_max or param_th<cfg_th_min, then param_th=cfg_th_min; else param_th+1.
  - cfg_frame_div=0 steps every frame.
  - cfg_th_min>cfg_th_max pins param_th at cfg_th_min.
  - No ack on sweep steps. param_mode is unchanged.
- cfg_th_min, cfg_th_max and cfg_frame_div are sampled live, not staged.
- IDLE: outputs hold. sof only advances frame_count.
- Timing: parameters change on the edge that accepts the first pixel of a frame and are visible from the next cycle. The core's own pipeline absorbs this one-beat skew; no pixel of the new frame is processed with stale settings at the core output.
- cfg_update held high for multiple cycles counts as repeated requests (same effect as one).

Test Plan:
- Reset, no stimulus -> param_mode=2'b10, param_th=5, frame_count=0, all flags 0. Assert aresetn low mid-PEND -> immediate return to these values.
- cfg_update(mode=1, th=9, auto=0), then sof 20 cycles later -> pending=1 for 20 cycles; param_th=9, mode=1 the cycle after sof; update_ack high exactly 1 cycle; state IDLE.
- Two cfg_updates (th=3, then th=7) before sof -> one ack; param_th=7.
- cfg_update coincident with sof while PEND(th=4), new th=11 -> th=4 applied with ack, pending stays 1; next sof -> th=11, second ack.
- Auto sweep: th=2, min=2, max=4, div=1 -> param_th across successive sofs: 2,2,3,3,4,4,2,... sweeping=1. A new cfg_update exits to PEND.
- 70000 sofs with FRAME_COUNT_WIDTH=16 -> frame_count wraps to 4464. mon_tvalid high with mon_tready low, tuser=1 -> no count.
